// File: rtl/rf_writeback_pkg.sv
// Shared types and constants for the write-back stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register count/address width used across the core, and the
// write-source tag that tells the scoreboard which writes retire a busy bit.
package rf_writeback_pkg;

  // Register file geometry shared with the decoder.
  localparam int NREGS_DEF = 16;
  localparam int RA_W      = 4;

  typedef logic [RA_W-1:0] reg_addr_t;

  // Origin of the write currently presented on we/rd/wdata.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_t;

endpackage

// File: rtl/rf_writeback_fifo.sv
// Small synchronous FIFO holding multi-cycle results {rd, data}.
// Latency: a pushed entry is visible on dout/!empty the cycle after the push.
// Backpressure: full is registered state only; push when full and pop when empty are ignored.
// Ports: clk, rst (sync, active-high); push/din write side; pop/dout read side
// (dout shows the head entry whenever !empty); full/empty derived from the count.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  // DEPTH is a power of two, so pointers wrap for free.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Write-back stage: merges ALU and buffered multi-cycle results into one register write per cycle, plus busy scoreboard.
// Latency: a result winning arbitration at edge N drives we=1 in cycle N+1 (written at edge N+2).
// Backpressure: mem_ready from FIFO fullness only; alu_ready drops for one cycle when a starved FIFO head is forced through.
// Ports: clk, rst (sync, active-high); alu_valid/alu_ready/alu_rd/alu_data single-cycle results;
// mem_valid/mem_ready/mem_rd/mem_data multi-cycle results; issue_valid/issue_rd mark a pending
// long-latency destination; busy scoreboard; we/rd/wdata register file write port.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int NREGS      = NREGS_DEF,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [RA_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  issue_rd,
  output logic [NREGS-1:0] busy,
  output logic             we,
  output logic [RA_W-1:0]  rd,
  output logic [XLEN-1:0]  wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int EW = RA_W + XLEN;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic [EW-1:0]   w_fifo_dout;
  logic            w_starved;
  logic            w_fifo_win;
  logic            w_alu_win;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_clr;

  logic [SW-1:0]    r_starve;
  logic             r_we;
  reg_addr_t        r_rd;
  logic [XLEN-1:0]  r_wdata;
  wb_src_t          r_src;
  logic [NREGS-1:0] r_busy;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({mem_rd, mem_data}),
    .pop   (w_fifo_win),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // mem_ready looks only at registered fullness, never at this cycle's pop.
  assign mem_ready = !w_full && !rst;
  assign w_push    = mem_valid && mem_ready;

  // FIFO takes the port when the ALU is idle, or when it has lost STARVE_MAX
  // times in a row; in the latter case the ALU is told to hold its result.
  assign w_starved  = (r_starve == SW'(STARVE_MAX));
  assign w_fifo_win = !w_empty && (!alu_valid || w_starved);
  assign w_alu_win  = alu_valid && !w_fifo_win;
  assign alu_ready  = !(!w_empty && w_starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_fifo_win) begin
      r_starve <= '0;
    end else if (w_alu_win && !w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Output registers; rd/wdata keep their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
      r_src   <= SRC_NONE;
    end else begin
      r_we <= w_fifo_win || w_alu_win;
      if (w_fifo_win) begin
        r_rd    <= w_fifo_dout[EW-1:XLEN];
        r_wdata <= w_fifo_dout[XLEN-1:0];
        r_src   <= SRC_FIFO;
      end else if (w_alu_win) begin
        r_rd    <= alu_rd;
        r_wdata <= alu_data;
        r_src   <= SRC_ALU;
      end else begin
        r_src   <= SRC_NONE;
      end
    end
  end

  // Only a FIFO-sourced write retires a pending destination; the clear lands on
  // the edge that actually writes the register file. A same-edge set wins.
  assign w_busy_set = issue_valid ? (NREGS'(1) << issue_rd) : '0;
  assign w_busy_clr = (r_src == SRC_FIFO) ? (NREGS'(1) << r_rd) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
    end
  end

  assign busy  = r_busy;
  assign we    = r_we;
  assign rd    = r_rd;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: a transaction-level model (queue FIFO,
// starvation count, busy bit array) predicts every register write and the
// ready/busy outputs; a separate monitor pops predicted writes when we=1.
module tb_rf_writeback;

  localparam int NREGS      = 16;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef logic [63:0] u64;
  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, alu_ready, mem_valid, mem_ready, issue_valid, we;
  logic [3:0]       alu_rd, mem_rd, issue_rd, rd;
  logic [XLEN-1:0]  alu_data, mem_data, wdata;
  logic [NREGS-1:0] busy;

  always #5 clk = ~clk;

  rf_writeback #(
    .NREGS      (NREGS),
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .we          (we),
    .rd          (rd),
    .wdata       (wdata)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  wr_t              exp_q[$];
  wr_t              m_fifo[$];
  int               m_starve = 0;
  logic [NREGS-1:0] m_busy   = '0;
  bit               m_pend_v = 1'b0;
  logic [3:0]       m_pend_rd = '0;

  // Requested stimulus for the next cycle; held transfers override it.
  bit          req_rst, req_alu_v, req_mem_v, req_iss_v;
  logic [3:0]  req_alu_rd, req_mem_rd, req_iss_rd;
  logic [31:0] req_alu_d, req_mem_d;
  bit          alu_hold = 1'b0;
  bit          mem_hold = 1'b0;

  task automatic chk(input string name, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check ready/busy, then
  // advance the model by the arbitration rules.
  task automatic step();
    bit  ne, starved, e_ar, e_mr, fifo_win, alu_win;
    wr_t e;
    logic [NREGS-1:0] nb;
    @(posedge clk);
    #2;
    rst = req_rst;
    if (req_rst) begin
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      alu_hold  = 1'b0;
      mem_hold  = 1'b0;
    end else begin
      if (!alu_hold) begin
        alu_valid = req_alu_v;
        alu_rd    = req_alu_rd;
        alu_data  = req_alu_d;
      end
      if (!mem_hold) begin
        mem_valid = req_mem_v;
        mem_rd    = req_mem_rd;
        mem_data  = req_mem_d;
      end
    end
    issue_valid = req_iss_v && !req_rst;
    issue_rd    = req_iss_rd;
    #1;
    chk("busy", u64'(busy), u64'(m_busy));
    if (req_rst) begin
      chk("mem_ready_in_reset", u64'(mem_ready), 64'd0);
      m_fifo.delete();
      m_starve = 0;
      m_busy   = '0;
      m_pend_v = 1'b0;
    end else begin
      ne      = (m_fifo.size() > 0);
      starved = (m_starve == STARVE_MAX);
      e_ar    = !(ne && starved);
      e_mr    = (m_fifo.size() < DEPTH);
      chk("alu_ready", u64'(alu_ready), u64'(e_ar));
      chk("mem_ready", u64'(mem_ready), u64'(e_mr));
      fifo_win = ne && (!alu_valid || starved);
      alu_win  = alu_valid && !fifo_win;
      nb = m_busy;
      if (m_pend_v) nb[m_pend_rd] = 1'b0;
      if (issue_valid) nb[issue_rd] = 1'b1;
      m_busy   = nb;
      m_pend_v = 1'b0;
      if (fifo_win) begin
        e = m_fifo.pop_front();
        exp_q.push_back(e);
        m_pend_v  = 1'b1;
        m_pend_rd = e.rd;
      end else if (alu_win) begin
        exp_q.push_back('{rd: alu_rd, data: alu_data});
      end
      if (mem_valid && e_mr) m_fifo.push_back('{rd: mem_rd, data: mem_data});
      if (!ne || fifo_win) m_starve = 0;
      else if (alu_win && m_starve < STARVE_MAX) m_starve++;
      alu_hold = alu_valid && !alu_win;
      mem_hold = mem_valid && !e_mr;
    end
  endtask

  task automatic req(input bit av, input logic [3:0] ard, input logic [31:0] ad,
                     input bit mv, input logic [3:0] mrd, input logic [31:0] md,
                     input bit iv, input logic [3:0] ird);
    req_rst = 1'b0;
    req_alu_v = av; req_alu_rd = ard; req_alu_d = ad;
    req_mem_v = mv; req_mem_rd = mrd; req_mem_d = md;
    req_iss_v = iv; req_iss_rd = ird;
    step();
  endtask

  // Percentages for alu/mem/issue/collision, per-mille for reset.
  task automatic rnd(input int p_alu, input int p_mem, input int p_iss,
                     input int p_col, input int p_rst);
    req_rst    = ($urandom_range(0, 999) < p_rst);
    req_alu_v  = ($urandom_range(0, 99) < p_alu);
    req_alu_rd = 4'($urandom_range(0, 15));
    req_alu_d  = $urandom();
    req_mem_v  = ($urandom_range(0, 99) < p_mem);
    req_mem_rd = 4'($urandom_range(0, 15));
    req_mem_d  = $urandom();
    req_iss_v  = ($urandom_range(0, 99) < p_iss);
    req_iss_rd = 4'($urandom_range(0, 15));
    if (m_pend_v && ($urandom_range(0, 99) < p_col)) begin
      req_iss_v  = 1'b1;
      req_iss_rd = m_pend_rd;
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rnd(0, 0, 0, 0, 0);
  endtask

  // Monitor: every presented write must be the oldest predicted write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_write actual rd=%0h wdata=%0h required no write", rd, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write", u64'({rd, wdata}), u64'({e.rd, e.data}));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    req_alu_v = 0; req_mem_v = 0; req_iss_v = 0;
    req_alu_rd = '0; req_mem_rd = '0; req_iss_rd = '0;
    req_alu_d = '0; req_mem_d = '0;
    req_rst = 1'b1;
    step();
    step();
    req_rst = 1'b0;
    step();
    chk("reset_we", u64'(we), 64'd0);
    chk("reset_rd", u64'(rd), 64'd0);
    chk("reset_wdata", u64'(wdata), 64'd0);

    // ALU write to r3.
    req(1, 4'd3, 32'hDEADBEEF, 0, '0, '0, 0, '0);
    idle(3);

    // Long-latency op to r5: issue, push three cycles later.
    req(0, '0, '0, 0, '0, '0, 1, 4'd5);
    idle(2);
    req(0, '0, '0, 1, 4'd5, 32'h1234, 0, '0);
    idle(4);

    // Starvation: one FIFO entry against a continuously valid ALU.
    req(1, 4'd1, 32'hA000_0000, 1, 4'd9, 32'h99, 0, '0);
    for (int i = 0; i < 8; i++) req(1, 4'(i), 32'hA000_0001 + 32'(i), 0, '0, '0, 0, '0);
    idle(3);

    // FIFO full: three mem results while the ALU keeps winning.
    for (int i = 0; i < 10; i++)
      req(1, 4'(i), 32'hB000_0000 + 32'(i), (i < 3), 4'(i + 2), 32'hC000_0000 + 32'(i), 0, '0);
    idle(6);

    // Set-and-clear collision on r7.
    req(0, '0, '0, 0, '0, '0, 1, 4'd7);
    req(0, '0, '0, 1, 4'd7, 32'h7777, 0, '0);
    for (int i = 0; i < 3; i++) rnd(0, 0, 0, 100, 0);
    idle(2);

    // Reset with two FIFO entries pending and busy bits set.
    req(1, 4'd2, 32'hD000_0000, 1, 4'd5, 32'h5555, 1, 4'd5);
    req(1, 4'd4, 32'hD000_0001, 1, 4'd7, 32'h7A7A, 1, 4'd7);
    req_rst = 1'b1;
    step();
    req_rst = 1'b0;
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i < 1000)      rnd(50, 60, 30, 20, 3);
      else if (i < 2000) rnd(95, 80, 40, 30, 2);
      else               rnd(20, 90, 50, 50, 5);
    end

    idle(12);
    @(negedge clk);
    #1;
    chk("drain", u64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
